forward_feed_reg: RTL and testbench
===================================

FORWARD_FEED_REG -- requirements
Module: forward_feed_reg

Interface
REQ-001 Parameter size, default 3: number of neuron lanes per bus.
REQ-002 Parameter data_size, default 16: bits per lane word.
REQ-003 Parameter forward_controll_size, default 32*3+4: width of the forward control word.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers a forward bundle this cycle.
REQ-007 in_ready  output  1  block accepts a bundle this cycle.
REQ-008 activation_in  input  size*data_size  layer input activations.
REQ-009 z_in  input  size*data_size  pre-activation sums.
REQ-010 predict_value_in  input  size*data_size  post-activation outputs.
REQ-011 forward_controll_in  input  forward_controll_size  forward control word.
REQ-012 flush  input  1  synchronous discard of all held bundles.
REQ-013 out_valid  output  1  a bundle is presented downstream.
REQ-014 out_ready  input  1  downstream accepts the presented bundle.
REQ-015 activation_out, z_out, predict_value_out  output  size*data_size each  presented bundle fields.
REQ-016 forward_controll_out  output  forward_controll_size  presented control word.
REQ-017 occupancy  output  2  number of held bundles, 0..2.

Function
REQ-018 The block SHALL be a 2-entry elastic stage: a head register drives the outputs, and a skid register stores one extra bundle.
REQ-019 The state machine SHALL have states EMPTY (occupancy 0), ONE (occupancy 1) and FULL (occupancy 2).
REQ-020 The push condition SHALL be in_valid&&in_ready; the pop condition SHALL be out_valid&&out_ready.
REQ-021 The handshake outputs SHALL be derived from state: in_ready=(state!=FULL) and out_valid=(state!=EMPTY), both decoded from registered state only, with no combinational path from any input.
REQ-022 EMPTY transitions: push moves to ONE and loads the head register the same edge, so the bundle is visible at the outputs one cycle after acceptance.
REQ-023 ONE transitions: push without pop moves to FULL (bundle into skid); pop without push moves to EMPTY; push with pop stays ONE (new bundle into head).
REQ-024 FULL transitions: pop moves to ONE (skid bundle moves into head); in_valid is ignored because in_ready=0.
REQ-025 Ordering SHALL be strict FIFO; no bundle is dropped or duplicated, except by flush or reset.
REQ-026 All four fields of a bundle SHALL travel together, bit-exact, with no arithmetic and no width change.
REQ-027 flush SHALL move the state to EMPTY on the next edge and override any simultaneous push or pop; a bundle offered in the flush cycle is discarded.
REQ-028 While out_valid=0, the data outputs SHALL hold their last value, and checkers SHALL treat them as don't-care.
REQ-029 The payload SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 Asserting reset SHALL immediately force state=EMPTY, occupancy=0, out_valid=0 and in_ready=1, and clear head and skid data to zero.
REQ-031 Reset asserted mid-transfer SHALL discard all held bundles; the first push after deassertion is the first bundle output.

Structure
REQ-032 The state encoding (EMPTY/ONE/FULL) and the default widths SHALL live in a shared neural-burning package, reused by the backprop-side stages.
REQ-033 One sub-module, forward_bundle_store (a resettable, enable-loaded register of the concatenated bundle), SHALL be instantiated twice, once for head and once for skid.

Verification
REQ-034 Reset, then push bundle A (z_in lane0=16'h0001) with out_ready=1 -> out_valid=1 next cycle with z_out lane0=16'h0001, and occupancy returns to 0 after the pop.
REQ-035 out_ready=0, push A then B -> occupancy=2 and in_ready=0; raise out_ready -> A then B on consecutive cycles.
REQ-036 Continuous in_valid=1 and out_ready=1 for 100 bundles with an incrementing counter payload -> one bundle per cycle, in order, with occupancy held at 1.
REQ-037 FULL plus flush plus simultaneous in_valid -> next cycle occupancy=0 and out_valid=0, and the offered bundle never appears.
REQ-038 Assert reset asynchronously mid-stream while FULL -> outputs clear without a clock edge; after release, the next pushed bundle C is the first output.
REQ-039 Random valid/ready backpressure for 10k cycles, checked against a scoreboard -> no loss, duplication or reordering, and the payload is stable under stall.

Source files
------------

// File: rtl/forward_feed_reg_pkg.sv
// Shared definitions for the neural-burning pipeline stages: default bus
// widths and the elastic-stage state encoding.
package forward_feed_reg_pkg;

    localparam int FFR_SIZE          = 3;
    localparam int FFR_DATA_SIZE     = 16;
    localparam int FFR_FWD_CTRL_SIZE = 32 * 3 + 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

    // Width of one concatenated bundle: three lane buses plus the control word.
    function automatic int bundle_width(input int size, input int data_size,
                                        input int fwd_ctrl_size);
        return 3 * size * data_size + fwd_ctrl_size;
    endfunction

endpackage

// File: rtl/forward_feed_reg_if.sv
// Forward bundle bus: upstream valid/ready side plus downstream valid/ready side.
// The stage itself takes the slave view; the producer/consumer takes the master view.
interface forward_feed_reg_if
    import forward_feed_reg_pkg::*;
#(
    parameter int size                  = FFR_SIZE,
    parameter int data_size             = FFR_DATA_SIZE,
    parameter int forward_controll_size = FFR_FWD_CTRL_SIZE
) ();

    logic                             in_valid;
    logic                             in_ready;
    logic [size*data_size-1:0]        activation_in;
    logic [size*data_size-1:0]        z_in;
    logic [size*data_size-1:0]        predict_value_in;
    logic [forward_controll_size-1:0] forward_controll_in;

    logic                             out_valid;
    logic                             out_ready;
    logic [size*data_size-1:0]        activation_out;
    logic [size*data_size-1:0]        z_out;
    logic [size*data_size-1:0]        predict_value_out;
    logic [forward_controll_size-1:0] forward_controll_out;

    modport slave (
        input  in_valid, activation_in, z_in, predict_value_in, forward_controll_in,
        input  out_ready,
        output in_ready,
        output out_valid, activation_out, z_out, predict_value_out, forward_controll_out
    );

    modport master (
        output in_valid, activation_in, z_in, predict_value_in, forward_controll_in,
        output out_ready,
        input  in_ready,
        input  out_valid, activation_out, z_out, predict_value_out, forward_controll_out
    );

endinterface

// File: rtl/forward_feed_reg_store.sv
// forward_bundle_store: one resettable, enable-loaded register holding a full
// concatenated forward bundle. Used for both the head and the skid entry.
module forward_bundle_store #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/forward_feed_reg.sv
// forward_feed_reg: 2-entry elastic stage for forward bundles. The head entry
// drives the outputs directly; the skid entry absorbs one bundle under stall.
module forward_feed_reg
    import forward_feed_reg_pkg::*;
#(
    parameter int size                  = FFR_SIZE,
    parameter int data_size             = FFR_DATA_SIZE,
    parameter int forward_controll_size = FFR_FWD_CTRL_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic [1:0]            occupancy,
    forward_feed_reg_if.slave     bus
);

    localparam int LANE_W   = size * data_size;
    localparam int BUNDLE_W = bundle_width(size, data_size, forward_controll_size);

    fifo_state_e         state_q, state_d;
    logic                push, pop;
    logic                head_load, skid_load, head_from_skid;
    logic [BUNDLE_W-1:0] in_bundle, head_d, head_q, skid_q;

    assign in_bundle = {bus.forward_controll_in, bus.predict_value_in,
                        bus.z_in, bus.activation_in};

    // Handshakes come from registered state only, so no input reaches them.
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign occupancy     = state_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d   = ONE;
                        head_load = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (!push && pop) begin
                        state_d = EMPTY;
                    end else if (push && pop) begin
                        head_load = 1'b1;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign head_d = head_from_skid ? skid_q : in_bundle;

    forward_bundle_store #(.WIDTH(BUNDLE_W)) u_head (
        .clk    (clk),
        .reset  (reset),
        .load_i (head_load),
        .d_i    (head_d),
        .q_o    (head_q)
    );

    forward_bundle_store #(.WIDTH(BUNDLE_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load_i (skid_load),
        .d_i    (in_bundle),
        .q_o    (skid_q)
    );

    assign bus.activation_out       = head_q[LANE_W-1:0];
    assign bus.z_out                = head_q[2*LANE_W-1:LANE_W];
    assign bus.predict_value_out    = head_q[3*LANE_W-1:2*LANE_W];
    assign bus.forward_controll_out = head_q[BUNDLE_W-1:3*LANE_W];

endmodule

// File: tb/tb_forward_feed_reg.sv
// Self-checking bench for forward_feed_reg: directed scenarios plus a random
// backpressure run against a queue model.
module tb_forward_feed_reg;

    localparam int SZ  = 3;
    localparam int DW  = 16;
    localparam int FCW = 32 * 3 + 4;
    localparam int LW  = SZ * DW;
    localparam int BW  = 3 * LW + FCW;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    int compared   = 0;
    int mismatched = 0;

    forward_feed_reg_if #(.size(SZ), .data_size(DW), .forward_controll_size(FCW)) bus ();

    forward_feed_reg #(.size(SZ), .data_size(DW), .forward_controll_size(FCW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .occupancy (occupancy),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [BW-1:0] outBundle;
    assign outBundle = {bus.forward_controll_out, bus.predict_value_out,
                        bus.z_out, bus.activation_out};

    // Every field of a bundle is derived from one tag so reordering shows up.
    function automatic logic [BW-1:0] make_bundle(input logic [15:0] t);
        logic [LW-1:0]  a, z, p;
        logic [FCW-1:0] f;
        for (int i = 0; i < SZ; i++) begin
            z[i*DW +: DW] = t + 16'(i);
            a[i*DW +: DW] = ~(t + 16'(i));
            p[i*DW +: DW] = (t + 16'(i)) ^ 16'hA5A5;
        end
        f = {4'(t), 32'(t) * 32'd7, ~32'(t), 16'hC0DE, t};
        return {f, p, z, a};
    endfunction

    task automatic drive(input logic v, input logic [BW-1:0] b);
        bus.in_valid            = v;
        bus.activation_in       = b[LW-1:0];
        bus.z_in                = b[2*LW-1:LW];
        bus.predict_value_in    = b[3*LW-1:2*LW];
        bus.forward_controll_in = b[BW-1:3*LW];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0);
        #1;
        compared++;
        if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: occ=%0d ov=%b ir=%b expected occ=0 ov=0 ir=1",
                     occupancy, bus.out_valid, bus.in_ready);
        end
        tick();
        compared++;
        if (outBundle !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %h expected 0", outBundle);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(1'b1, make_bundle(16'h0001));
        tick();
        drive(1'b0, '0);
        compared++;
        if (bus.out_valid !== 1'b1 || bus.z_out[15:0] !== 16'h0001 || occupancy !== 2'd1) begin
            mismatched++;
            $display("[TB] FAIL single_out: ov=%b z0=%h occ=%0d expected ov=1 z0=0001 occ=1",
                     bus.out_valid, bus.z_out[15:0], occupancy);
        end
        compared++;
        if (outBundle !== make_bundle(16'h0001)) begin
            mismatched++;
            $display("[TB] FAIL single_bundle: got %h expected %h", outBundle, make_bundle(16'h0001));
        end
        tick();
        compared++;
        if (occupancy !== 2'd0 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_pop: occ=%0d ov=%b expected occ=0 ov=0", occupancy, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, make_bundle(16'h00A0));
        tick();
        drive(1'b1, make_bundle(16'h00B0));
        tick();
        compared++;
        if (occupancy !== 2'd2 || bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL bp_full: occ=%0d ir=%b expected occ=2 ir=0", occupancy, bus.in_ready);
        end
        drive(1'b1, make_bundle(16'h00D0));
        tick();
        compared++;
        if (occupancy !== 2'd2 || outBundle !== make_bundle(16'h00A0)) begin
            mismatched++;
            $display("[TB] FAIL bp_stall: occ=%0d out=%h expected occ=2 out=%h",
                     occupancy, outBundle, make_bundle(16'h00A0));
        end
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        tick();
        compared++;
        if (bus.out_valid !== 1'b1 || occupancy !== 2'd1 || outBundle !== make_bundle(16'h00B0)) begin
            mismatched++;
            $display("[TB] FAIL bp_second: ov=%b occ=%0d out=%h expected ov=1 occ=1 out=%h",
                     bus.out_valid, occupancy, outBundle, make_bundle(16'h00B0));
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b0 || occupancy !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL bp_drain: ov=%b occ=%0d expected ov=0 occ=0", bus.out_valid, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, make_bundle(16'(16'h0100 + i)));
            tick();
            compared++;
            if (bus.out_valid !== 1'b1 || occupancy !== 2'd1 ||
                outBundle !== make_bundle(16'(16'h0100 + i))) begin
                mismatched++;
                $display("[TB] FAIL b2b_%0d: ov=%b occ=%0d z0=%h expected ov=1 occ=1 z0=%h",
                         i, bus.out_valid, occupancy, bus.z_out[15:0], 16'(16'h0100 + i));
            end
        end
        drive(1'b0, '0);
        tick();
        compared++;
        if (occupancy !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain: occ=%0d expected 0", occupancy);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, make_bundle(16'h0E00));
        tick();
        drive(1'b1, make_bundle(16'h0F00));
        tick();
        flush = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, make_bundle(16'h0600));
        tick();
        flush = 1'b0;
        drive(1'b0, '0);
        compared++;
        if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flush_empty: occ=%0d ov=%b ir=%b expected occ=0 ov=0 ir=1",
                     occupancy, bus.out_valid, bus.in_ready);
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flush_stays: ov=%b expected 0", bus.out_valid);
        end
        drive(1'b1, make_bundle(16'h0700));
        tick();
        drive(1'b0, '0);
        compared++;
        if (bus.out_valid !== 1'b1 || outBundle !== make_bundle(16'h0700)) begin
            mismatched++;
            $display("[TB] FAIL flush_next: ov=%b z0=%h expected ov=1 z0=0700",
                     bus.out_valid, bus.z_out[15:0]);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        drive(1'b1, make_bundle(16'h0800));
        tick();
        drive(1'b1, make_bundle(16'h0900));
        tick();
        drive(1'b0, '0);
        compared++;
        if (occupancy !== 2'd2) begin
            mismatched++;
            $display("[TB] FAIL areset_pre: occ=%0d expected 2", occupancy);
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (occupancy !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            outBundle !== '0) begin
            mismatched++;
            $display("[TB] FAIL areset_now: occ=%0d ov=%b ir=%b out=%h expected occ=0 ov=0 ir=1 out=0",
                     occupancy, bus.out_valid, bus.in_ready, outBundle);
        end
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, make_bundle(16'h0C00));
        tick();
        drive(1'b0, '0);
        compared++;
        if (bus.out_valid !== 1'b1 || outBundle !== make_bundle(16'h0C00)) begin
            mismatched++;
            $display("[TB] FAIL areset_first: ov=%b z0=%h expected ov=1 z0=0C00",
                     bus.out_valid, bus.z_out[15:0]);
        end
        tick();
    endtask

    task automatic test_random();
        logic [BW-1:0] q[$];
        logic [BW-1:0] prevOut;
        logic          prevStall;
        logic [15:0]   tag;
        logic          v;
        int            printed;
        printed   = 0;
        prevStall = 1'b0;
        prevOut   = '0;
        tag       = 16'h1000;
        for (int c = 0; c < 10000; c++) begin
            compared++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2) ||
                occupancy !== 2'(q.size())) begin
                mismatched++;
                if (printed < 20) begin
                    printed++;
                    $display("[TB] FAIL rand_flags@%0d: ov=%b ir=%b occ=%0d expected occ=%0d",
                             c, bus.out_valid, bus.in_ready, occupancy, q.size());
                end
            end
            if (q.size() > 0) begin
                compared++;
                if (outBundle !== q[0]) begin
                    mismatched++;
                    if (printed < 20) begin
                        printed++;
                        $display("[TB] FAIL rand_order@%0d: z0=%h expected z0=%h",
                                 c, bus.z_out[15:0], q[0][LW +: DW]);
                    end
                end
            end
            if (prevStall) begin
                compared++;
                if (outBundle !== prevOut) begin
                    mismatched++;
                    if (printed < 20) begin
                        printed++;
                        $display("[TB] FAIL rand_stable@%0d: got %h expected %h", c, outBundle, prevOut);
                    end
                end
            end
            v = ($urandom_range(0, 99) < 60);
            bus.out_ready = ($urandom_range(0, 99) < 55);
            drive(v, make_bundle(tag));
            prevStall = bus.out_valid && !bus.out_ready;
            prevOut   = outBundle;
            if (q.size() > 0 && bus.out_ready) begin
                void'(q.pop_front());
            end
            if (v && (bus.in_ready === 1'b1)) begin
                q.push_back(make_bundle(tag));
                tag = tag + 16'd1;
            end
            tick();
        end
        drive(1'b0, '0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8 && occupancy != 2'd0; k++) begin
            tick();
        end
        compared++;
        if (occupancy !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL rand_drain: occ=%0d expected 0", occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
